// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every non-clock signal of mem_arbiter.
//   Requester side : if_*  (instruction fetch), mem_* (load/store)
//   Memory side    : bus_* (single 32-bit external bus, req/ack handshake)
//   Pipeline side  : stallreq_if / stallreq_mem, err
// Modports:
//   master - the arbiter (drives rdata/done, bus request attributes, stalls, err)
//   slave  - the environment (requesters + memory model)
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_done;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        stallreq_if;
  logic        stallreq_mem;
  logic        err;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  bus_ack, bus_rdata,
    output if_rdata, if_done,
    output mem_rdata, mem_done,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output stallreq_if, stallreq_mem, err
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output bus_ack, bus_rdata,
    input  if_rdata, if_done,
    input  mem_rdata, mem_done,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  stallreq_if, stallreq_mem, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit external memory bus between the instruction
// fetch requester (IF) and the load/store requester (MEM).
//   - Fixed MEM-over-IF priority; after MAX_MEM_GRANTS consecutive MEM grants
//     with IF pending, IF is granted next.
//   - Three-state flow IDLE -> BUS -> RESP -> IDLE; done is a one-cycle
//     registered pulse in RESP, only if the requester still holds req.
//   - stallreq_* are combinational: req & ~done.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   arb  - mem_arbiter_if.master (requester, bus, stall and err signals)
// Parameters:
//   MAX_MEM_GRANTS - MEM grant streak limit while IF waits
//   TIMEOUT_CYCLES - bus_ack watchdog limit (used with MEM_ARB_TIMEOUT_EN)
// Build option:
//   MEM_ARB_TIMEOUT_EN - when defined, a BUS-state watchdog aborts the access
//   after TIMEOUT_CYCLES cycles, pulses err and returns NOP / zero data.
//   When undefined, BUS waits indefinitely and err is tied low.
module mem_arbiter #(
  parameter int unsigned MAX_MEM_GRANTS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master arb
);

  localparam int unsigned CW = (MAX_MEM_GRANTS < 1) ? 1 : $clog2(MAX_MEM_GRANTS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_MEM_GRANTS);
  localparam logic [31:0]   IF_NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic        gnt_mem_q,   gnt_mem_d;
  logic        bus_req_q,   bus_req_d;
  logic        bus_we_q,    bus_we_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wmask_q, bus_wmask_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_done_q,   if_done_d;
  logic        mem_done_q,  mem_done_d;

  // BUS completion: either a real bus_ack or a watchdog expiry.
  logic        complete;
  logic        timed_out;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // Next-state and output register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_mem_d   = gnt_mem_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    complete    = 1'b0;
    timed_out   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d       = 1'b0;
    // Counter is zero in every state but BUS, so it restarts on each BUS entry.
    tmo_d       = (state_q == S_BUS) ? tmo_q + 16'd1 : '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (arb.mem_req && ((cnt_q < CNT_MAX) || !arb.if_req)) begin
          state_d     = S_BUS;
          gnt_mem_d   = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = arb.mem_we;
          bus_addr_d  = arb.mem_addr;
          bus_wdata_d = arb.mem_wdata;
          bus_wmask_d = arb.mem_wmask;
          // Streak only counts while IF is actually waiting.
          if (!arb.if_req) begin
            cnt_d = '0;
          end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (arb.if_req) begin
          state_d     = S_BUS;
          gnt_mem_d   = 1'b0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = arb.if_addr;
          bus_wdata_d = '0;
          bus_wmask_d = '1;
          cnt_d       = '0;
        end
      end

      S_BUS: begin
        if (arb.bus_ack) begin
          complete = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          complete  = 1'b1;
          timed_out = 1'b1;
        end
`endif
        if (complete) begin
          state_d   = S_RESP;
          bus_req_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          err_d     = timed_out;
`endif
          // rdata is captured even if the requester withdrew; done is not.
          if (gnt_mem_q) begin
            if (timed_out) begin
              mem_rdata_d = '0;
            end else if (!bus_we_q) begin
              mem_rdata_d = arb.bus_rdata;
            end
            mem_done_d = arb.mem_req;
          end else begin
            if_rdata_d = timed_out ? IF_NOP : arb.bus_rdata;
            if_done_d  = arb.if_req;
          end
        end
      end

      S_RESP: begin
        // No grant here: a requester dropping req after done is not re-served.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_mem_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_mem_q   <= gnt_mem_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign arb.err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) | timed_out;
  assign arb.err = 1'b0;
`endif

  assign arb.bus_req   = bus_req_q;
  assign arb.bus_we    = bus_we_q;
  assign arb.bus_addr  = bus_addr_q;
  assign arb.bus_wdata = bus_wdata_q;
  assign arb.bus_wmask = bus_wmask_q;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.mem_rdata = mem_rdata_q;
  assign arb.if_done   = if_done_q;
  assign arb.mem_done  = mem_done_q;

  assign arb.stallreq_if  = arb.if_req  & ~if_done_q;
  assign arb.stallreq_mem = arb.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, scoreboard-based bench for mem_arbiter.
// Expected bus transactions and completions are queued when requests are
// raised and checked in order as the arbiter issues them on the bus.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus_if ();

  mem_arbiter #(
    .MAX_MEM_GRANTS(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bus_if)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_t;

  typedef struct {
    bit          is_mem;
    bit          done;
    bit          upd;
    logic [31:0] rdata;
  } cmp_t;

  bus_t bus_q[$];
  cmp_t cmp_q[$];

  int total = 0;
  int bad   = 0;
  logic [31:0] if_rd_m;
  logic [31:0] mem_rd_m;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void exp_bus(input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [3:0] m);
    bus_t t;
    t.we = we; t.addr = a; t.wdata = wd; t.wmask = m;
    bus_q.push_back(t);
  endfunction

  function automatic void exp_cmp(input bit is_mem, input bit done,
                                  input bit upd, input logic [31:0] rd);
    cmp_t t;
    t.is_mem = is_mem; t.done = done; t.upd = upd; t.rdata = rd;
    cmp_q.push_back(t);
  endfunction

  task automatic wait_grant();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_if.bus_req === 1'b1) ok = 1'b1;
      else tick();
    end
    chk1("grant_seen", ok, 1'b1);
  endtask

  // Wait for a grant, check it against the scoreboard, ack after lat cycles,
  // then check the completion cycle.
  task automatic serve(input int lat, input logic [31:0] rd, input bit drop_if);
    bus_t e;
    cmp_t c;
    wait_grant();
    if (bus_q.size() == 0 || cmp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%0d/%0d expected=nonempty", bus_q.size(), cmp_q.size());
      return;
    end
    e = bus_q.pop_front();
    c = cmp_q.pop_front();
    chk1("bus_we", bus_if.bus_we, e.we);
    chk("bus_addr", bus_if.bus_addr, e.addr);
    chk("bus_wmask", {28'd0, bus_if.bus_wmask}, {28'd0, e.wmask});
    if (e.we) chk("bus_wdata", bus_if.bus_wdata, e.wdata);
    if (drop_if) bus_if.if_req = 1'b0;
    repeat (lat) tick();
    chk1("bus_req_hold", bus_if.bus_req, 1'b1);
    chk("bus_addr_hold", bus_if.bus_addr, e.addr);
    chk1("stall_in_bus", c.is_mem ? bus_if.stallreq_mem : bus_if.stallreq_if,
         c.is_mem ? bus_if.mem_req : bus_if.if_req);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = rd;
    tick();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = $urandom;
    if (c.upd) begin
      if (c.is_mem) mem_rd_m = c.rdata;
      else          if_rd_m  = c.rdata;
    end
    chk1("bus_req_drop", bus_if.bus_req, 1'b0);
    chk1("if_done", bus_if.if_done, !c.is_mem && c.done);
    chk1("mem_done", bus_if.mem_done, c.is_mem && c.done);
    chk("if_rdata", bus_if.if_rdata, if_rd_m);
    chk("mem_rdata", bus_if.mem_rdata, mem_rd_m);
    chk1("stallreq_if", bus_if.stallreq_if, bus_if.if_req && !(!c.is_mem && c.done));
    chk1("stallreq_mem", bus_if.stallreq_mem, bus_if.mem_req && !(c.is_mem && c.done));
    chk1("err_quiet", bus_if.err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_wmask = '0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    if_rd_m  = '0;
    mem_rd_m = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk1("rst_bus_req", bus_if.bus_req, 1'b0);
    chk1("rst_bus_we", bus_if.bus_we, 1'b0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_bus_wmask", {28'd0, bus_if.bus_wmask}, 32'h0);
    chk("rst_if_rdata", bus_if.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus_if.mem_rdata, 32'h0);
    chk1("rst_if_done", bus_if.if_done, 1'b0);
    chk1("rst_mem_done", bus_if.mem_done, 1'b0);
    chk1("rst_err", bus_if.err, 1'b0);

    // Reset in the middle of a bus access
    bus_if.if_addr = 32'h40;
    bus_if.if_req  = 1'b1;
    tick();
    chk1("midbus_req", bus_if.bus_req, 1'b1);
    chk("midbus_addr", bus_if.bus_addr, 32'h40);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_bus_req", bus_if.bus_req, 1'b0);
    chk("async_rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("async_rst_wmask", {28'd0, bus_if.bus_wmask}, 32'h0);
    bus_if.if_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_0000;
    tick();
    bus_if.bus_ack = 1'b0;
    chk1("late_ack_if_done", bus_if.if_done, 1'b0);
    chk1("late_ack_mem_done", bus_if.mem_done, 1'b0);
    chk("late_ack_if_rdata", bus_if.if_rdata, 32'h0);
    tick();
    chk1("late_ack_if_done2", bus_if.if_done, 1'b0);
    chk1("late_ack_bus_req", bus_if.bus_req, 1'b0);

    // IF only
    exp_bus(1'b0, 32'h100, 32'h0, 4'hF);
    exp_cmp(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
    bus_if.if_addr = 32'h100;
    bus_if.if_req  = 1'b1;
    serve(3, 32'hDEADBEEF, 1'b0);
    bus_if.if_req = 1'b0;
    tick();
    chk1("if_done_once", bus_if.if_done, 1'b0);

    // Simultaneous requests: store first, IF second
    bus_if.mem_we    = 1'b1;
    bus_if.mem_addr  = 32'h2000;
    bus_if.mem_wdata = 32'h55AA55AA;
    bus_if.mem_wmask = 4'b0011;
    bus_if.if_addr   = 32'h300;
    bus_if.mem_req   = 1'b1;
    bus_if.if_req    = 1'b1;
    exp_bus(1'b1, 32'h2000, 32'h55AA55AA, 4'b0011);
    exp_cmp(1'b1, 1'b1, 1'b0, 32'h0);
    exp_bus(1'b0, 32'h300, 32'h0, 4'hF);
    exp_cmp(1'b0, 1'b1, 1'b1, 32'hCAFE0001);
    serve(1, 32'hBADBAD00, 1'b0);
    bus_if.mem_req = 1'b0;
    bus_if.mem_we  = 1'b0;
    serve(2, 32'hCAFE0001, 1'b0);
    bus_if.if_req = 1'b0;
    tick();

    // Starvation guard: 4 MEM grants, forced IF, then MEM again
    bus_if.mem_we    = 1'b0;
    bus_if.mem_wmask = 4'hF;
    bus_if.mem_addr  = 32'h1000;
    bus_if.if_addr   = 32'h400;
    bus_if.mem_req   = 1'b1;
    bus_if.if_req    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_bus(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'hF);
      exp_cmp(1'b1, 1'b1, 1'b1, 32'h11110000 + 32'(i));
    end
    exp_bus(1'b0, 32'h400, 32'h0, 4'hF);
    exp_cmp(1'b0, 1'b1, 1'b1, 32'h22220000);
    exp_bus(1'b0, 32'h1010, 32'h0, 4'hF);
    exp_cmp(1'b1, 1'b1, 1'b1, 32'h11110004);
    exp_bus(1'b0, 32'h404, 32'h0, 4'hF);
    exp_cmp(1'b0, 1'b1, 1'b1, 32'h22220001);
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'h11110000 + 32'(i), 1'b0);
      bus_if.mem_addr = 32'h1000 + 32'(4 * (i + 1));
    end
    serve(1, 32'h22220000, 1'b0);
    bus_if.if_addr = 32'h404;
    serve(1, 32'h11110004, 1'b0);
    bus_if.mem_req = 1'b0;
    serve(1, 32'h22220001, 1'b0);
    bus_if.if_req = 1'b0;
    tick();

    // Flush: IF withdraws during BUS
    bus_if.if_addr = 32'h500;
    bus_if.if_req  = 1'b1;
    exp_bus(1'b0, 32'h500, 32'h0, 4'hF);
    exp_cmp(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    serve(2, 32'h0BADF00D, 1'b1);
    tick();
    chk1("flush_if_done_after", bus_if.if_done, 1'b0);
    bus_if.mem_addr = 32'h3000;
    bus_if.mem_req  = 1'b1;
    exp_bus(1'b0, 32'h3000, 32'h0, 4'hF);
    exp_cmp(1'b1, 1'b1, 1'b1, 32'h33333333);
    serve(1, 32'h33333333, 1'b0);
    bus_if.mem_req = 1'b0;
    tick();

    // Stray bus_ack in IDLE
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h77777777;
    tick();
    bus_if.bus_ack = 1'b0;
    chk1("stray_ack_bus_req", bus_if.bus_req, 1'b0);
    chk1("stray_ack_if_done", bus_if.if_done, 1'b0);
    chk1("stray_ack_mem_done", bus_if.mem_done, 1'b0);
    tick();
    chk("stray_ack_mem_rdata", bus_if.mem_rdata, mem_rd_m);
    chk("stray_ack_if_rdata", bus_if.if_rdata, if_rd_m);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ack for an IF read
    bus_if.if_addr = 32'h600;
    bus_if.if_req  = 1'b1;
    wait_grant();
    repeat (7) tick();
    chk1("tmo_err_early", bus_if.err, 1'b0);
    chk1("tmo_bus_req_early", bus_if.bus_req, 1'b1);
    tick();
    chk1("tmo_err", bus_if.err, 1'b1);
    chk1("tmo_if_done", bus_if.if_done, 1'b1);
    chk("tmo_if_rdata", bus_if.if_rdata, 32'h00000013);
    chk1("tmo_bus_req", bus_if.bus_req, 1'b0);
    if_rd_m = 32'h00000013;
    bus_if.if_req = 1'b0;
    tick();
    chk1("tmo_err_pulse", bus_if.err, 1'b0);
    chk1("tmo_if_done_pulse", bus_if.if_done, 1'b0);
    tick();
    chk1("tmo_idle", bus_if.bus_req, 1'b0);
    bus_if.mem_addr = 32'h3004;
    bus_if.mem_req  = 1'b1;
    exp_bus(1'b0, 32'h3004, 32'h0, 4'hF);
    exp_cmp(1'b1, 1'b1, 1'b1, 32'h44444444);
    serve(1, 32'h44444444, 1'b0);
    bus_if.mem_req = 1'b0;
    tick();
`endif

    chk("sb_bus_drained", 32'(bus_q.size()), 32'd0);
    chk("sb_cmp_drained", 32'(cmp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 32-bit external memory bus between the instruction-fetch requester (IF) and the load/store requester (MEM stage).
- Fixed MEM-over-IF priority, with an anti-starvation limit for IF.
- Produces per-requester stall requests consumed by the pipeline stall controller, which drives stall[5:0] into the pipeline registers.

Parameters:
- MAX_MEM_GRANTS, 4, max consecutive MEM grants while IF is pending before IF is forced.
- TIMEOUT_CYCLES, 64, bus_ack watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF read request; held until if_done
- if_addr  in  32  IF word address
- if_rdata  out  32  IF read data, valid when if_done=1
- if_done  out  1  one-cycle IF completion pulse
- mem_req  in  1  MEM request; held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  store data
- mem_wmask  in  4  byte enables for store
- mem_rdata  out  32  load data, valid when mem_done=1
- mem_done  out  1  one-cycle MEM completion pulse
- bus_req  out  1  bus request, held until bus_ack
- bus_we  out  1  bus write enable
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_wmask  out  4  bus byte enables (4'b1111 for IF reads)
- bus_ack  in  1  one-cycle bus completion
- bus_rdata  in  32  bus read data, valid with bus_ack
- stallreq_if  out  1  IF stall request
- stallreq_mem  out  1  MEM stall request
- err  out  1  timeout error pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, immediate): state=IDLE.
  - All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, if_rdata, mem_rdata, if_done, mem_done, err.
  - Grant counter = 0.
  - Reset mid-transaction abandons it silently; a late bus_ack while in IDLE is ignored.
- States:
  - IDLE: evaluate requests at the clock edge.
    - mem_req and (cnt<MAX_MEM_GRANTS or !if_req): grant MEM.
    - Else if_req: grant IF.
    - Granting latches bus attributes into registers, sets bus_req=1 and enters BUS.
  - BUS: hold bus_req and all attributes stable. On bus_ack: bus_req=0, capture bus_rdata into the granted port's rdata register, enter RESP.
  - RESP (one cycle): granted port's done=1 (registered pulse), then IDLE. No new grant in RESP, so a requester dropping req after done is never re-granted.
- Minimum latency: req seen at edge 0 -> bus_req high after edge 0 -> ack at edge k -> done high for one cycle after edge k (RESP) -> IDLE.
- Grant counter:
  - Increments on a MEM grant while if_req=1.
  - Clears on any IF grant, or on a MEM grant with if_req=0.
  - Saturates at MAX_MEM_GRANTS.
- Stall requests are combinational:
  - stallreq_if = if_req & ~if_done
  - stallreq_mem = mem_req & ~mem_done
- Request withdrawn (flush) during BUS: the bus transaction completes normally. In RESP, done is asserted only if the requester's req is still 1; rdata is updated regardless.
- Simultaneous if_req/mem_req in IDLE: MEM wins unless the counter is saturated.
- Stores: bus_rdata is ignored; mem_rdata retains its previous value; mem_done still pulses.
- bus_ack outside BUS: ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in BUS.
  - If TIMEOUT_CYCLES cycles elapse without bus_ack: drop bus_req, pulse err for one cycle, enter RESP. The granted done is pulsed with rdata=32'h00000013 (NOP) for IF and 32'h0 for MEM.
  - Counter clears on state entry.
- Undefined: no counter; BUS waits indefinitely; err tied 0.

Test Plan:
- Reset: assert rst mid-BUS with bus_req=1 -> all outputs 0 immediately; a later bus_ack produces no done.
- IF only: if_req=1, if_addr=32'h100; bus_ack 3 cycles after bus_req with rdata=32'hDEADBEEF -> bus_addr=32'h100, bus_wmask=4'hF, if_rdata=32'hDEADBEEF, if_done pulses exactly once, stallreq_if falls with if_done.
- Simultaneous: if_req and mem_req (store, addr 32'h2000, wdata 32'h55AA55AA, wmask 4'b0011) -> MEM serviced first (bus_we=1, bus_wmask=4'b0011), then IF; stallreq_if stays high until if_done.
- Starvation: mem_req held continuously (re-asserted each op), if_req=1, MAX_MEM_GRANTS=4 -> exactly 4 MEM grants, then one IF grant, then the counter restarts.
- Flush: drop if_req during BUS -> bus transaction completes, if_done stays 0, next mem_req granted normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ack never asserted for IF read -> err pulses after 8 BUS cycles, if_done=1 with if_rdata=32'h00000013, arbiter returns to IDLE.
